// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: default widths and FSM state type.
package div_pkg;

    localparam int unsigned N_W_DEF   = 16;
    localparam int unsigned D_W_DEF   = 8;
    localparam int unsigned CNT_W_DEF = $clog2(N_W_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration: shift in the next dividend bit, trial-subtract.
module div_step #(
    parameter int unsigned D_W = 8
) (
    input  logic [D_W-1:0] r_in,
    input  logic           q_bit_in,
    input  logic [D_W-1:0] divisor,
    output logic [D_W-1:0] r_out,
    output logic           q_bit
);

    logic [D_W:0] r_shift;
    logic [D_W:0] div_ext;

    always_comb begin
        r_shift = {r_in, q_bit_in};
        div_ext = {1'b0, divisor};
        q_bit   = (r_shift >= div_ext);
        // After a successful subtract the result is below divisor, so it fits in D_W bits.
        r_out   = q_bit ? D_W'(r_shift - div_ext) : r_shift[D_W-1:0];
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock, valid/ready on both sides.
// Optional DIV_ZERO_SHORTCUT_EN: a zero divisor skips the iterations and completes in one cycle.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int unsigned N_W = N_W_DEF,
    parameter int unsigned D_W = D_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N_W-1:0] quotient,
    output logic [D_W-1:0] remainder,
    output logic           div_zero
);

    localparam int unsigned CNT_W = $clog2(N_W);

    state_t         state;
    logic [CNT_W-1:0] count;
    logic [N_W-1:0] q_sr;
    logic [D_W-1:0] r;
    logic [D_W-1:0] divisor_q;

    logic [D_W-1:0] r_next;
    logic           q_bit;
    logic [N_W-1:0] q_next;

    div_step #(.D_W(D_W)) u_step (
        .r_in     (r),
        .q_bit_in (q_sr[N_W-1]),
        .divisor  (divisor_q),
        .r_out    (r_next),
        .q_bit    (q_bit)
    );

    assign q_next = {q_sr[N_W-2:0], q_bit};

    // Control FSM plus datapath registers; all outputs are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            count     <= '0;
            q_sr      <= '0;
            r         <= '0;
            divisor_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        q_sr      <= dividend;
                        r         <= '0;
                        count     <= '0;
                        divisor_q <= divisor;
                        div_zero  <= (divisor == '0);
                        in_ready  <= 1'b0;
`ifdef DIV_ZERO_SHORTCUT_EN
                        if (divisor == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            quotient  <= '1;
                            remainder <= dividend[D_W-1:0];
                        end else begin
                            state <= RUN;
                        end
`else
                        state <= RUN;
`endif
                    end
                end
                RUN: begin
                    q_sr  <= q_next;
                    r     <= r_next;
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(N_W - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        quotient  <= q_next;
                        remainder <= r_next;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
